// File: rtl/fetch_unit_pkg.sv
// Shared widths for the instruction-fetch front end.
package fetch_unit_pkg;

    localparam int unsigned InstAddrWidth = 32;
    localparam int unsigned InstDataWidth = 32;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush, combined push/pop and a flop-backed head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // A push into a full FIFO is accepted only when a pop frees the slot.
        do_push  = push_i & ((count_q != CntW'(DEPTH)) | pop_i);
        do_pop   = pop_i & (count_q != '0);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, ROM request tracking, redirect/flush and a
// prefetch FIFO presenting a valid/stall instruction stream to decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = InstAddrWidth,
    parameter int unsigned           DATA_WIDTH = InstDataWidth,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           PC_STEP    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         rom_data_in,
    input  logic                          redirect_valid,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc,
    input  logic                          stall_in,
    output logic [ADDR_WIDTH-1:0]         rom_addr_out,
    output logic                          rom_enable,
    output logic                          inst_valid_out,
    output logic [DATA_WIDTH-1:0]         inst_data_out,
    output logic [ADDR_WIDTH-1:0]         inst_pc_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0]            pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]            pending_pc_q, pending_pc_d;
    logic                             pending_q, pending_d;
    logic                             pop, push, issue;
    logic [CntW:0]                    occ_next;
    logic [CntW-1:0]                  count;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

    always_comb begin
        pop      = (count != '0) & ~stall_in & ~redirect_valid;
        push     = pending_q & ~redirect_valid;
        // Occupancy once this cycle's response lands; issuing needs a free slot left.
        occ_next = {1'b0, count} + (CntW + 1)'(pending_q) - (CntW + 1)'(pop);
        issue    = ~rst & ~redirect_valid & (occ_next <= (CntW + 1)'(FIFO_DEPTH - 1));

        pc_d         = pc_q;
        pending_d    = 1'b0;
        pending_pc_d = pending_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d         = pc_q + ADDR_WIDTH'(PC_STEP);
            pending_d    = 1'b1;
            pending_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({pending_pc_q, rom_data_in}),
        .rdata_o (head),
        .count_o (count)
    );

    assign rom_addr_out   = pc_q;
    assign rom_enable     = issue;
    assign inst_valid_out = (count != '0);
    assign inst_pc_out    = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign inst_data_out  = head[DATA_WIDTH-1:0];
    assign fifo_count     = count;

endmodule
